// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus for data_mem_arbiter: one instance per requester.
// master = requester (CPU stage or loader), slave = arbiter.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter for the single DataMemory port: round-robin with locked bursts.
// Define MEM_ARB_FIXED_PRIO_EN to give requester A fixed priority over B.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  data_mem_arbiter_if.slave   a,
  data_mem_arbiter_if.slave   b,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                mem_write,
  output logic                mem_read,
  input  logic [31:0]         mem_rdata
);

  localparam int unsigned CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_a_rvalid;
  logic             r_b_rvalid;
  logic [31:0]      r_a_rdata;
  logic [31:0]      r_b_rdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic             r_last_b;
`endif

  logic w_a_gnt;
  logic w_b_gnt;
  logic w_a_hold;
  logic w_b_hold;

  assign w_a_gnt  = (r_state == OWN_A) && a.req;
  assign w_b_gnt  = (r_state == OWN_B) && b.req;
  assign w_a_hold = w_a_gnt && a.lock && (r_burst_cnt < BURST_LAST);
  assign w_b_hold = w_b_gnt && b.lock && (r_burst_cnt < BURST_LAST);

  assign a.gnt    = w_a_gnt;
  assign b.gnt    = w_b_gnt;
  assign a.rvalid = r_a_rvalid;
  assign b.rvalid = r_b_rvalid;
  assign a.rdata  = r_a_rdata;
  assign b.rdata  = r_b_rdata;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (w_a_gnt) begin
      mem_addr  = 32'(a.addr);
      mem_wdata = a.wdata;
      mem_write = a.we;
      mem_read  = ~a.we;
    end else if (w_b_gnt) begin
      mem_addr  = 32'(b.addr);
      mem_wdata = b.wdata;
      mem_write = b.we;
      mem_read  = ~b.we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_last_b    <= 1'b1;
`endif
    end else begin
      r_a_rvalid <= w_a_gnt & ~a.we;
      r_b_rvalid <= w_b_gnt & ~b.we;
      if (w_a_gnt && !a.we) r_a_rdata <= mem_rdata;
      if (w_b_gnt && !b.we) r_b_rdata <= mem_rdata;

      case (r_state)
        IDLE: begin
          r_burst_cnt <= '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
          if (a.req)      r_state <= OWN_A;
          else if (b.req) r_state <= OWN_B;
`else
          if (a.req && (!b.req || r_last_b)) begin
            r_state  <= OWN_A;
            r_last_b <= 1'b0;
          end else if (b.req) begin
            r_state  <= OWN_B;
            r_last_b <= 1'b1;
          end
`endif
        end
        OWN_A: begin
          if (w_a_hold) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
`ifdef MEM_ARB_FIXED_PRIO_EN
          // B only takes over when A has stopped asking
          end else if (b.req && !a.req) begin
`else
          end else if (b.req) begin
            r_last_b    <= 1'b1;
`endif
            r_state     <= OWN_B;
            r_burst_cnt <= '0;
          end else begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
          end
        end
        OWN_B: begin
          if (w_b_hold) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
          end else if (a.req) begin
`ifndef MEM_ARB_FIXED_PRIO_EN
            r_last_b    <= 1'b0;
`endif
            r_state     <= OWN_A;
            r_burst_cnt <= '0;
          end else begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_burst_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 64-word DataMemory model.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic [31:0] tb_mem [64];
  logic        mem_init;

  int n_checks;
  int n_pass;

  data_mem_arbiter_if #(.ADDR_W(6)) a_if ();
  data_mem_arbiter_if #(.ADDR_W(6)) b_if ();

  data_mem_arbiter #(.ADDR_W(6), .BURST_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a_if.slave),
    .b         (b_if.slave),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int unsigned i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int unsigned i = 0; i < 64; i++) tb_mem[i] <= init_val(i);
    end else if (mem_write) begin
      tb_mem[mem_addr[5:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = tb_mem[mem_addr[5:0]];

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drop_all;
    a_if.req = 1'b0; a_if.lock = 1'b0; a_if.we = 1'b0;
    b_if.req = 1'b0; b_if.lock = 1'b0; b_if.we = 1'b0;
  endtask

  task automatic test_reset;
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 6'd1; a_if.wdata = '0; a_if.lock = 1'b0;
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 6'd2; b_if.wdata = '0; b_if.lock = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_cycle(); settle();
      n_checks++;
      if ({a_if.gnt, b_if.gnt, a_if.rvalid, b_if.rvalid, mem_write, mem_read} !== 6'b0)
        $display("FAIL rst_outputs cyc=%0d got=%b exp=000000", k,
                 {a_if.gnt, b_if.gnt, a_if.rvalid, b_if.rvalid, mem_write, mem_read});
      else n_pass++;
    end
    n_checks++;
    if ({a_if.rdata, b_if.rdata, mem_addr} !== 96'b0)
      $display("FAIL rst_data got a=%h b=%h addr=%h exp=0", a_if.rdata, b_if.rdata, mem_addr);
    else n_pass++;
    rst_n = 1'b1; settle();
    n_checks++;
    if ({a_if.gnt, b_if.gnt} !== 2'b00) $display("FAIL rel_c0_gnt got=%b exp=00", {a_if.gnt, b_if.gnt});
    else n_pass++;
    next_cycle(); settle();
    n_checks++;
    if ({a_if.gnt, b_if.gnt} !== 2'b10) $display("FAIL rel_c1_gnt got=%b exp=10", {a_if.gnt, b_if.gnt});
    else n_pass++;
    next_cycle(); settle();
    n_checks++;
    if ({a_if.gnt, b_if.gnt} !== 2'b01) $display("FAIL rel_c2_gnt got=%b exp=01", {a_if.gnt, b_if.gnt});
    else n_pass++;
    n_checks++;
    if (a_if.rvalid !== 1'b1 || a_if.rdata !== 32'hA500_0001)
      $display("FAIL rel_a_read got v=%b d=%h exp v=1 d=a5000001", a_if.rvalid, a_if.rdata);
    else n_pass++;
    next_cycle(); drop_all(); settle();
    n_checks++;
    if (b_if.rvalid !== 1'b1 || b_if.rdata !== 32'hA500_0002)
      $display("FAIL rel_b_read got v=%b d=%h exp v=1 d=a5000002", b_if.rvalid, b_if.rdata);
    else n_pass++;
    next_cycle(); next_cycle();
  endtask

  task automatic test_write_read;
    a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 6'd5; a_if.wdata = 32'hDEAD_BEEF;
    settle();
    n_checks++;
    if (a_if.gnt !== 1'b0) $display("FAIL wr_idle_gnt got=%b exp=0", a_if.gnt);
    else n_pass++;
    next_cycle(); settle();
    n_checks++;
    if ({a_if.gnt, mem_write, mem_read} !== 3'b110 || mem_addr !== 32'd5 || mem_wdata !== 32'hDEAD_BEEF)
      $display("FAIL wr_bus got gnt/w/r=%b addr=%h wdata=%h exp 110 addr=5 wdata=deadbeef",
               {a_if.gnt, mem_write, mem_read}, mem_addr, mem_wdata);
    else n_pass++;
    next_cycle();
    a_if.req = 1'b0; a_if.we = 1'b0;
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 6'd5;
    settle();
    n_checks++;
    if ({a_if.rvalid, b_if.gnt} !== 2'b00) $display("FAIL wr_after got rvalid/bgnt=%b exp=00", {a_if.rvalid, b_if.gnt});
    else n_pass++;
    next_cycle(); settle();
    n_checks++;
    if (b_if.gnt !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 32'd5)
      $display("FAIL rd_bus got gnt=%b rd=%b addr=%h exp gnt=1 rd=1 addr=5", b_if.gnt, mem_read, mem_addr);
    else n_pass++;
    next_cycle(); b_if.req = 1'b0; settle();
    n_checks++;
    if (b_if.rvalid !== 1'b1 || b_if.rdata !== 32'hDEAD_BEEF)
      $display("FAIL rd_data got v=%b d=%h exp v=1 d=deadbeef", b_if.rvalid, b_if.rdata);
    else n_pass++;
    next_cycle(); settle();
    n_checks++;
    if (b_if.rvalid !== 1'b0 || b_if.rdata !== 32'hDEAD_BEEF)
      $display("FAIL rd_hold got v=%b d=%h exp v=0 d=deadbeef", b_if.rvalid, b_if.rdata);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_lock_burst;
    // cycle: 0 1 2 3 4 5 6 7 8 ; A locked for 4, B once, A resumes
    logic [8:0] exp_a;
    logic [8:0] exp_b;
    int a_done;
    int b_done;
    exp_a = 9'b011011110;
    exp_b = 9'b000100000;
    a_done = 0; b_done = 0;
    a_if.we = 1'b0; a_if.lock = 1'b1; a_if.addr = 6'd12;
    b_if.we = 1'b0; b_if.lock = 1'b0; b_if.addr = 6'd13;
    for (int c = 0; c < 9; c++) begin
      a_if.req = (a_done < 6);
      b_if.req = (b_done < 1);
      settle();
      n_checks++;
      if ({a_if.gnt, b_if.gnt} !== {exp_a[c], exp_b[c]})
        $display("FAIL lock_gnt cyc=%0d got=%b exp=%b", c, {a_if.gnt, b_if.gnt}, {exp_a[c], exp_b[c]});
      else n_pass++;
      if (c > 0) begin
        n_checks++;
        if ({a_if.rvalid, b_if.rvalid} !== {exp_a[c-1], exp_b[c-1]})
          $display("FAIL lock_rvalid cyc=%0d got=%b exp=%b", c, {a_if.rvalid, b_if.rvalid}, {exp_a[c-1], exp_b[c-1]});
        else n_pass++;
      end
      if (exp_a[c]) a_done++;
      if (exp_b[c]) b_done++;
      next_cycle();
    end
    n_checks++;
    if (a_if.rdata !== init_val(12) || b_if.rdata !== init_val(13))
      $display("FAIL lock_rdata got a=%h b=%h exp a=%h b=%h", a_if.rdata, b_if.rdata, init_val(12), init_val(13));
    else n_pass++;
    drop_all();
    next_cycle(); next_cycle();
  endtask

  task automatic test_alternate;
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.lock = 1'b0; a_if.addr = 6'd7;
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.lock = 1'b0; b_if.addr = 6'd8;
    for (int c = 0; c < 9; c++) begin
      logic ea, eb, pa, pb;
      ea = (c >= 2) && (c % 2 == 0);
      eb = (c % 2 == 1);
      pa = (c >= 3) && (c % 2 == 1);
      pb = (c >= 2) && (c % 2 == 0);
      settle();
      n_checks++;
      if ({a_if.gnt, b_if.gnt} !== {ea, eb})
        $display("FAIL alt_gnt cyc=%0d got=%b exp=%b", c, {a_if.gnt, b_if.gnt}, {ea, eb});
      else n_pass++;
      n_checks++;
      if ({a_if.rvalid, b_if.rvalid} !== {pa, pb})
        $display("FAIL alt_rvalid cyc=%0d got=%b exp=%b", c, {a_if.rvalid, b_if.rvalid}, {pa, pb});
      else n_pass++;
      if (pa) begin
        n_checks++;
        if (a_if.rdata !== init_val(7)) $display("FAIL alt_a_rdata cyc=%0d got=%h exp=%h", c, a_if.rdata, init_val(7));
        else n_pass++;
      end
      if (pb) begin
        n_checks++;
        if (b_if.rdata !== init_val(8)) $display("FAIL alt_b_rdata cyc=%0d got=%h exp=%h", c, b_if.rdata, init_val(8));
        else n_pass++;
      end
      next_cycle();
    end
    drop_all();
    next_cycle(); next_cycle();
  endtask

  task automatic test_reset_midburst;
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.lock = 1'b1; a_if.addr = 6'd20;
    settle();
    next_cycle(); settle();
    n_checks++;
    if (a_if.gnt !== 1'b1) $display("FAIL mid_beat1 got=%b exp=1", a_if.gnt);
    else n_pass++;
    next_cycle();
    a_if.we = 1'b1; a_if.addr = 6'd21; a_if.wdata = 32'hCAFE_F00D;
    settle();
    n_checks++;
    if ({a_if.gnt, a_if.rvalid, mem_write} !== 3'b111)
      $display("FAIL mid_beat2 got gnt/rv/w=%b exp=111", {a_if.gnt, a_if.rvalid, mem_write});
    else n_pass++;
    rst_n = 1'b0; settle();
    n_checks++;
    if ({a_if.gnt, b_if.gnt, a_if.rvalid, b_if.rvalid, mem_write, mem_read} !== 6'b0 || a_if.rdata !== 32'd0)
      $display("FAIL mid_rst got=%b rdata=%h exp=000000 rdata=0",
               {a_if.gnt, b_if.gnt, a_if.rvalid, b_if.rvalid, mem_write, mem_read}, a_if.rdata);
    else n_pass++;
    next_cycle();
    n_checks++;
    if (tb_mem[21] !== init_val(21)) $display("FAIL mid_nowrite got=%h exp=%h", tb_mem[21], init_val(21));
    else n_pass++;
    a_if.we = 1'b0; a_if.lock = 1'b0; a_if.addr = 6'd3;
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 6'd4;
    rst_n = 1'b1; settle();
    n_checks++;
    if ({a_if.gnt, b_if.gnt} !== 2'b00) $display("FAIL mid_rel_idle got=%b exp=00", {a_if.gnt, b_if.gnt});
    else n_pass++;
    next_cycle(); settle();
    n_checks++;
    if ({a_if.gnt, b_if.gnt} !== 2'b10) $display("FAIL mid_rel_first got=%b exp=10", {a_if.gnt, b_if.gnt});
    else n_pass++;
    drop_all();
    next_cycle(); next_cycle();
  endtask

  task automatic test_fixed_prio;
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.lock = 1'b0; a_if.addr = 6'd3;
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.lock = 1'b0; b_if.addr = 6'd4;
    for (int c = 0; c < 8; c++) begin
      logic ea, eb;
      if (c == 6) a_if.req = 1'b0;
      ea = (c < 6) && (c % 2 == 1);
      eb = (c == 7);
      settle();
      n_checks++;
      if ({a_if.gnt, b_if.gnt} !== {ea, eb})
        $display("FAIL fix_gnt cyc=%0d got=%b exp=%b", c, {a_if.gnt, b_if.gnt}, {ea, eb});
      else n_pass++;
      next_cycle();
    end
    drop_all();
    next_cycle(); next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    mem_init = 1'b1;
    rst_n    = 1'b0;
    drop_all();
    a_if.addr = '0; a_if.wdata = '0;
    b_if.addr = '0; b_if.wdata = '0;
    @(posedge clk); #1;
    mem_init = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    rst_n = 1'b1;
    next_cycle();
    test_write_read();
    test_fixed_prio();
    test_reset_midburst();
`else
    test_reset();
    test_write_read();
    test_lock_burst();
    test_alternate();
    test_reset_midburst();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
